rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter that shares a single downstream resource (bus/port) among requesters 0..3.
- Winner is the first asserted request at or above a rotating start position, wrapping past 3 to 0; the same lowest-set-bit scan as the 4-bit position encoders, applied to a rotated vector.
- Holds a grant while the owner keeps requesting, up to a bounded tenure, then forces rotation.
- Sits between requester logic and the shared-resource mux; gnt_id drives the mux select directly.

---
 rtl/rr_arbiter4.sv | 145 ++++++++++++++
 tb/tb_rr_arbiter4.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with bounded grant tenure.
//
// Purpose:
//   Shares one downstream resource among requesters 0..3.
//   - The winner is the first set request at or above a rotating start
//     position, wrapping past 3 back to 0.
//   - An owner keeps the grant while it keeps requesting, but only for up to
//     MAX_HOLD consecutive cycles. At that point the grant is re-arbitrated
//     and the owner has the lowest priority.
//   - Handovers happen in a single edge, with no idle cycle between grants.
//
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles per tenure. 0 = unlimited.
//              Legal range 0..255.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req[3:0]   level-sensitive request vector, bit k = requester k
//   gnt[3:0]   registered one-hot grant, all-zero when idle
//   gnt_valid  registered, high while a grant is held
//   gnt_id     registered index of the current or most recent grant
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // hold_cnt value at which the tenure expires. It is only used when
  // MAX_HOLD != 0.
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  // start_q holds the scan start position, which is the last winner + 1.
  // It is kept separately from gnt_id because after reset the start must be
  // 0, while gnt_id reads 0.
  logic [1:0] start_q, start_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  // Rotate req so that rot[0] is the requester at the start position.
  logic [3:0] rot;
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    logic [1:0] src;
    assign src     = start_q + 2'(gi);
    assign rot[gi] = req[src];
  end

  // Find the lowest set bit of the rotated vector. Scanning from the top
  // down means the last match wins, which is the lowest index.
  logic [1:0] offs;
  always_comb begin
    offs = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) offs = 2'(k);
    end
  end

  logic       any_req;
  logic [1:0] winner;
  assign any_req = |req;
  assign winner  = start_q + offs;

  // In GRANT state the start position is always owner + 1. The same winner
  // therefore serves both release and timeout: on release the owner's bit
  // is already clear, and on timeout the owner is scanned last.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    start_d     = start_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_GRANT;
          gnt_d       = 4'b0001 << winner;
          gnt_valid_d = 1'b1;
          gnt_id_d    = winner;
          start_d     = winner + 2'd1;
          hold_cnt_d  = 8'd0;
        end
      end
      default: begin
        if (!req[gnt_id_q]) begin
          if (any_req) begin
            gnt_d       = 4'b0001 << winner;
            gnt_id_d    = winner;
            start_d     = winner + 2'd1;
            hold_cnt_d  = 8'd0;
          end else begin
            // gnt_id keeps the last owner while idle.
            state_d     = ST_IDLE;
            gnt_d       = 4'b0000;
            gnt_valid_d = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
          // Tenure expired. A sole requester is simply re-granted here.
          gnt_d      = 4'b0001 << winner;
          gnt_id_d   = winner;
          start_d    = winner + 2'd1;
          hold_cnt_d = 8'd0;
        end else if (hold_cnt_q != 8'hFF) begin
          // Saturate the count so that unlimited tenures never wrap.
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      start_q     <= 2'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      start_q     <= start_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4 -- scoreboard bench for rr_arbiter4.
//
// Two instances are used:
//   dut_a has MAX_HOLD = 4.
//   dut_b has MAX_HOLD = 0, which is unlimited tenure.
//
// How stimulus and checking work:
//   - Each directed step drives req and reset on a falling edge.
//   - It also queues the hand-computed outputs expected after the next
//     rising edge.
//   - A monitor samples 1 time unit after each rising edge, pops the queue
//     and compares.
module tb_rr_arbiter4;

  logic       clk;
  logic       reset;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic       gnt_valid_a, gnt_valid_b;
  logic [1:0] gnt_id_a, gnt_id_b;

  rr_arbiter4 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(reset), .req(req_a),
    .gnt(gnt_a), .gnt_valid(gnt_valid_a), .gnt_id(gnt_id_a)
  );

  rr_arbiter4 #(.MAX_HOLD(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b),
    .gnt(gnt_b), .gnt_valid(gnt_valid_b), .gnt_id(gnt_id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel_b;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  // Monitor: compares one queued expectation per rising edge.
  initial begin
    exp_t       e;
    logic [3:0] ag;
    logic       av;
    logic [1:0] ai;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ag = e.sel_b ? gnt_b       : gnt_a;
        av = e.sel_b ? gnt_valid_b : gnt_valid_a;
        ai = e.sel_b ? gnt_id_b    : gnt_id_a;
        tests++;
        if (ag !== e.gnt || ai !== e.id || av !== (e.gnt != 4'b0000)) begin
          fails++;
          $display("[TB] FAIL %s dut=%s req=%b: got gnt=%b valid=%b id=%0d, need gnt=%b valid=%b id=%0d",
                   e.name, e.sel_b ? "B" : "A", e.req, ag, av, ai,
                   e.gnt, (e.gnt != 4'b0000), e.id);
        end else begin
          $display("[TB] ok   %s dut=%s req=%b gnt=%b valid=%b id=%0d",
                   e.name, e.sel_b ? "B" : "A", e.req, ag, av, ai);
        end
      end
    end
  end

  task automatic step(input bit sel_b, input logic rst, input logic [3:0] r,
                      input logic [3:0] eg, input logic [1:0] eid,
                      input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    if (sel_b) begin
      req_b = r;
      req_a = 4'b0000;
    end else begin
      req_a = r;
      req_b = 4'b0000;
    end
    e.sel_b = sel_b;
    e.req   = r;
    e.gnt   = eg;
    e.id    = eid;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [1:0] w;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req_a = 4'b0000;
    req_b = 4'b0000;

    // 1: reset state, one-cycle request-to-grant, then release to idle.
    step(0, 1, 4'b0000, 4'b0000, 2'd0, "reset");
    step(0, 0, 4'b0000, 4'b0000, 2'd0, "idle");
    step(0, 0, 4'b0001, 4'b0001, 2'd0, "first_grant");
    step(0, 0, 4'b0000, 4'b0000, 2'd0, "release_idle");

    // 2: all requesting, tenure of 4, rotation with no gaps.
    step(0, 1, 4'b0000, 4'b0000, 2'd0, "reset");
    for (int i = 0; i < 17; i++) begin
      w = 2'((i / 4) % 4);
      step(0, 0, 4'b1111, 4'b0001 << w, w, "rotate_all");
    end

    // 3: release handover without a bubble, then idle keeps gnt_id.
    step(0, 1, 4'b0000, 4'b0000, 2'd0, "reset");
    step(0, 0, 4'b0101, 4'b0001, 2'd0, "grant_0");
    step(0, 0, 4'b0100, 4'b0100, 2'd2, "handover_2");
    step(0, 0, 4'b0000, 4'b0000, 2'd2, "idle_keep_id");

    // 4: sole requester re-granted on timeout; start=3 wraps to pick 1.
    step(0, 1, 4'b0000, 4'b0000, 2'd0, "reset");
    for (int i = 0; i < 12; i++) step(0, 0, 4'b0100, 4'b0100, 2'd2, "sole_hold");
    step(0, 0, 4'b0110, 4'b0010, 2'd1, "timeout_wrap");

    // Owner keeps its grant while a new request waits; wrap on release.
    step(0, 0, 4'b0011, 4'b0010, 2'd1, "hold_with_waiter");
    step(0, 0, 4'b1001, 4'b1000, 2'd3, "release_to_3");
    step(0, 0, 4'b0001, 4'b0001, 2'd0, "release_wrap_0");

    // 5: unlimited tenure never rotates while the owner requests.
    step(1, 1, 4'b0000, 4'b0000, 2'd0, "reset");
    for (int i = 0; i < 50; i++) step(1, 0, 4'b0011, 4'b0001, 2'd0, "unlimited_hold");
    step(1, 0, 4'b0010, 4'b0010, 2'd1, "unlimited_release");
    step(1, 0, 4'b0000, 4'b0000, 2'd1, "unlimited_idle");

    // 6: mid-grant reset clears outputs and the start pointer.
    step(0, 1, 4'b0000, 4'b0000, 2'd0, "reset");
    step(0, 0, 4'b1000, 4'b1000, 2'd3, "grant_3");
    step(0, 1, 4'b1010, 4'b0000, 2'd0, "mid_reset");
    step(0, 0, 4'b1010, 4'b0010, 2'd1, "after_reset");

    // Allow the monitor to drain the last expectation, with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
